// File: rtl/median3x3_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : median3x3_stream_pkg
//  Purpose  : Shared defaults and types for the 3x3 streaming median filter.
//             c_DEF_PIX_W / c_DEF_IMG_W / c_DEF_IMG_H are the default pixel
//             width and raster size. tag_t is the per-window marker bundle
//             (valid / start-of-frame / end-of-line) that travels alongside
//             the pixel data through the sorter pipeline.
//  Revision : 1.0  initial release
// ============================================================================
package median3x3_stream_pkg;

    localparam int c_DEF_PIX_W = 8;
    localparam int c_DEF_IMG_W = 640;
    localparam int c_DEF_IMG_H = 480;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/median9_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : median9_pipe
//  Purpose  : Three-stage pipelined median-of-nine sorting network.
//             S1 sorts each window row, S2 takes max(lo), med(mid), min(hi),
//             S3 takes the median of those three. Tags ride along unchanged.
//  Ports    : clk    - rising-edge clock
//             rst_n  - synchronous active-low reset (tags and output only)
//             i_win  - 9 x PIX_W window, element k = row*3 + col
//             i_tag  - valid/sof/eol markers for i_win
//             o_pix  - median, 3 cycles after i_win
//             o_tag  - markers aligned with o_pix
//  Revision : 1.0  initial release
// ============================================================================
module median9_pipe
    import median3x3_stream_pkg::*;
#(
    parameter int PIX_W = c_DEF_PIX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9*PIX_W-1:0] i_win,
    input  tag_t               i_tag,
    output logic [PIX_W-1:0]   o_pix,
    output tag_t               o_tag
);

    function automatic logic [PIX_W-1:0] f_min2(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] f_max2(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    // median of three: max(min(a,b), min(max(a,b),c))
    function automatic logic [PIX_W-1:0] f_med3(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return f_max2(f_min2(a, b), f_min2(f_max2(a, b), c));
    endfunction

    logic [PIX_W-1:0] w_lo  [3];
    logic [PIX_W-1:0] w_mid [3];
    logic [PIX_W-1:0] w_hi  [3];

    logic [PIX_W-1:0] r_s1_lo  [3];
    logic [PIX_W-1:0] r_s1_mid [3];
    logic [PIX_W-1:0] r_s1_hi  [3];
    logic [PIX_W-1:0] r_s2_maxlo;
    logic [PIX_W-1:0] r_s2_medmid;
    logic [PIX_W-1:0] r_s2_minhi;
    logic [PIX_W-1:0] r_s3_pix;

    tag_t r_tag_s1;
    tag_t r_tag_s2;
    tag_t r_tag_s3;

    // Row sorter inputs: element (row, col) lives at index row*3+col.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_row
            logic [PIX_W-1:0] w_a;
            logic [PIX_W-1:0] w_b;
            logic [PIX_W-1:0] w_c;
            assign w_a      = i_win[(g*3+0)*PIX_W +: PIX_W];
            assign w_b      = i_win[(g*3+1)*PIX_W +: PIX_W];
            assign w_c      = i_win[(g*3+2)*PIX_W +: PIX_W];
            assign w_lo[g]  = f_min2(f_min2(w_a, w_b), w_c);
            assign w_mid[g] = f_med3(w_a, w_b, w_c);
            assign w_hi[g]  = f_max2(f_max2(w_a, w_b), w_c);
        end
    endgenerate

    // Data path stages 1-2 carry no reset; only the tags decide validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            r_s1_lo[i]  <= w_lo[i];
            r_s1_mid[i] <= w_mid[i];
            r_s1_hi[i]  <= w_hi[i];
        end
        r_s2_maxlo  <= f_max2(f_max2(r_s1_lo[0], r_s1_lo[1]), r_s1_lo[2]);
        r_s2_medmid <= f_med3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
        r_s2_minhi  <= f_min2(f_min2(r_s1_hi[0], r_s1_hi[1]), r_s1_hi[2]);
    end

    // The output register is cleared on reset so the top-level pixel port
    // reads zero straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_s1 <= '0;
            r_tag_s2 <= '0;
            r_tag_s3 <= '0;
            r_s3_pix <= '0;
        end else begin
            r_tag_s1 <= i_tag;
            r_tag_s2 <= r_tag_s1;
            r_tag_s3 <= r_tag_s2;
            r_s3_pix <= f_med3(r_s2_maxlo, r_s2_medmid, r_s2_minhi);
        end
    end

    assign o_pix = r_s3_pix;
    assign o_tag = r_tag_s3;

endmodule
`default_nettype wire

// File: rtl/median3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module   : median3x3_stream
//  Purpose  : Streaming 3x3 median filter for 8-bit grayscale rasters.
//             Two line buffers feed a 3x3 window register; median9_pipe
//             picks the median. Only fully populated windows are emitted
//             (inner (IMG_W-2)x(IMG_H-2) pixels), 4 cycles after the pixel
//             that completes the window.
//  Ports    : clk       - pixel clock, rising edge
//             rst_n     - synchronous active-low reset
//             in_pix    - grayscale pixel, raster order
//             in_valid  - in_pix valid, no backpressure
//             in_sof    - first pixel of frame (qualified by in_valid)
//             out_pix   - median of window centred on (r-1, c-1)
//             out_valid - out_pix valid
//             out_sof   - first output of frame
//             out_eol   - last output of each line
//  Revision : 1.0  initial release
// ============================================================================
module median3x3_stream
    import median3x3_stream_pkg::*;
#(
    parameter int IMG_W = c_DEF_IMG_W,
    parameter int IMG_H = c_DEF_IMG_H,
    parameter int PIX_W = c_DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol
);

    localparam int              c_CW       = $clog2(IMG_W);
    localparam int              c_RW       = $clog2(IMG_H);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);

    logic [c_CW-1:0]    r_col_cnt;
    logic [c_RW-1:0]    r_row_cnt;
    logic [c_CW-1:0]    w_col;
    logic [c_RW-1:0]    w_row;

    logic [PIX_W-1:0]   r_lb0 [IMG_W];   // row r-1
    logic [PIX_W-1:0]   r_lb1 [IMG_W];   // row r-2
    logic [PIX_W-1:0]   w_lb0_rd;
    logic [PIX_W-1:0]   w_lb1_rd;

    logic [PIX_W-1:0]   r_win [3][3];    // [row][col], row 2 = current, col 2 = newest
    logic [9*PIX_W-1:0] w_win_flat;
    tag_t               r_win_tag;
    tag_t               w_win_tag;
    tag_t               w_out_tag;

    // in_sof pins the current pixel to (0,0) whatever the counters say.
    assign w_col = in_sof ? '0 : r_col_cnt;
    assign w_row = in_sof ? '0 : r_row_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (in_valid) begin
            if (w_col == c_COL_LAST) begin
                r_col_cnt <= '0;
                r_row_cnt <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col_cnt <= w_col + 1'b1;
                r_row_cnt <= w_row;
            end
        end
    end

    // Line buffers: read old contents and write new ones on the same edge.
    // Not reset; rows are only trusted once row_cnt proves they were written.
    assign w_lb0_rd = r_lb0[w_col];
    assign w_lb1_rd = r_lb1[w_col];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb0[w_col] <= in_pix;
            r_lb1[w_col] <= w_lb0_rd;
        end
    end

    always_comb begin
        w_win_tag       = '0;
        w_win_tag.valid = in_valid && (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);
        w_win_tag.sof   = w_win_tag.valid && (w_row == c_ROW_TWO) && (w_col == c_COL_TWO);
        w_win_tag.eol   = w_win_tag.valid && (w_col == c_COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_win_tag <= '0;
        end else begin
            r_win_tag <= w_win_tag;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb1_rd;
                r_win[1][2] <= w_lb0_rd;
                r_win[2][2] <= in_pix;
            end
        end
    end

    generate
        for (genvar gr = 0; gr < 3; gr++) begin : g_win_row
            for (genvar gc = 0; gc < 3; gc++) begin : g_win_col
                assign w_win_flat[(gr*3+gc)*PIX_W +: PIX_W] = r_win[gr][gc];
            end
        end
    endgenerate

    median9_pipe #(
        .PIX_W (PIX_W)
    ) u_median9_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_win (w_win_flat),
        .i_tag (r_win_tag),
        .o_pix (out_pix),
        .o_tag (w_out_tag)
    );

    assign out_valid = w_out_tag.valid;
    assign out_sof   = w_out_tag.sof;
    assign out_eol   = w_out_tag.eol;

endmodule
`default_nettype wire

// File: tb/tb_median3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_median3x3_stream
//  Purpose  : Self-checking bench for median3x3_stream at IMG_W=8, IMG_H=6.
//             A scoreboard queue holds the expected median, markers and
//             output cycle for every complete window driven in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_median3x3_stream;

    localparam int c_W   = 8;
    localparam int c_H   = 6;
    localparam int c_LAT = 4;

    typedef struct {
        int pix;
        bit sof;
        bit eol;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_pix = '0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] out_pix;
    logic       out_valid;
    logic       out_sof;
    logic       out_eol;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;
    int   n_sof = 0;
    int   n_eol = 0;
    int   tb_row = 0;
    int   tb_col = 0;
    int   img [c_H][c_W];
    exp_t sb [$];

    median3x3_stream #(
        .IMG_W (c_W),
        .IMG_H (c_H),
        .PIX_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int gold_med(input int r, input int c);
        int v [9];
        int t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[i*3+j] = img[r-2+i][c-2+j];
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        return v[4];
    endfunction

    function automatic int gen(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return (r == 2 && c == 3) ? 255 : ((r == 3 && c == 5) ? 0 : 50);
            2: return 8*r + c;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send(input int p, input bit sof);
        int r;
        int c;
        exp_t e;
        @(negedge clk);
        r = sof ? 0 : tb_row;
        c = sof ? 0 : tb_col;
        img[r][c] = p;
        in_valid = 1'b1;
        in_pix   = 8'(p);
        in_sof   = sof;
        if (r >= 2 && c >= 2) begin
            e.pix = gold_med(r, c);
            e.sof = (r == 2 && c == 2);
            e.eol = (c == c_W - 1);
            e.cyc = cyc + 1 + (c_LAT - 1);
            sb.push_back(e);
        end
        if (c == c_W - 1) begin
            tb_col = 0;
            tb_row = (r == c_H - 1) ? 0 : r + 1;
        end else begin
            tb_col = c + 1;
            tb_row = r;
        end
    endtask

    task automatic send_frame(input int kind, input int gap, input bit sof_first, input int npix);
        int r;
        int c;
        bit s;
        for (int k = 0; k < npix; k++) begin
            while (int'($urandom_range(0, 99)) < gap) idle();
            s = sof_first && (k == 0);
            r = s ? 0 : tb_row;
            c = s ? 0 : tb_col;
            send(gen(kind, r, c), s);
        end
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain_q", sb.size(), 0);
    endtask

    task automatic clr_cnt();
        n_out = 0;
        n_sof = 0;
        n_eol = 0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid) begin
            n_out++;
            if (out_sof) n_sof++;
            if (out_eol) n_eol++;
            if (sb.size() == 0) begin
                check("unexp_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pix", int'(out_pix), e.pix);
                check("sof", int'(out_sof), int'(e.sof));
                check("eol", int'(out_eol), int'(e.eol));
                check("lat", cyc, e.cyc);
            end
        end else if (out_sof || out_eol) begin
            check("tag_no_valid", 1, 0);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_pix",   int'(out_pix),   0);
        check("rst_sof",   int'(out_sof),   0);
        check("rst_eol",   int'(out_eol),   0);
        rst_n = 1'b1;
        tb_row = 0;
        tb_col = 0;

        // constant frame
        clr_cnt();
        send_frame(0, 0, 1'b1, c_W*c_H);
        drain();
        check("const_cnt", n_out, 24);
        check("const_sof", n_sof, 1);
        check("const_eol", n_eol, 4);

        // salt & pepper, no in_sof: wrap after IMG_H lines starts a new frame
        clr_cnt();
        send_frame(1, 0, 1'b0, c_W*c_H);
        drain();
        check("sp_cnt", n_out, 24);
        check("sp_sof", n_sof, 1);

        // ramp
        clr_cnt();
        send_frame(2, 0, 1'b1, c_W*c_H);
        drain();
        check("ramp_cnt", n_out, 24);

        // random image with ~40% idle cycles
        for (int f = 0; f < 2; f++) begin
            clr_cnt();
            send_frame(3, 40, 1'b1, c_W*c_H);
            drain();
            check("rand_cnt", n_out, 24);
            check("rand_eol", n_eol, 4);
        end

        // mid-frame in_sof at (3,4): 8 old outputs then a full new frame
        clr_cnt();
        send_frame(2, 0, 1'b1, 3*c_W + 4);
        send_frame(3, 0, 1'b1, c_W*c_H);
        drain();
        check("msof_cnt", n_out, 8 + 24);
        check("msof_sof", n_sof, 2);
        check("msof_eol", n_eol, 5);

        // reset mid-frame
        send_frame(3, 0, 1'b1, 3*c_W + 5);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        while (sb.size() != 0 && sb[sb.size()-1].cyc >= cyc + 1) void'(sb.pop_back());
        @(negedge clk);
        check("rstm_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        tb_row = 0;
        tb_col = 0;
        clr_cnt();
        send_frame(3, 20, 1'b0, c_W*c_H);
        drain();
        check("rstm_cnt", n_out, 24);
        check("rstm_sof", n_sof, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
